spi_master_ctrl: RTL and testbench

SPI master transaction controller, mode 0 (CPOL=0, CPHA=0), MSB first. It sequences a DATA_W-bit transmit/receive shift register, generates SCLK, CS_N and MOSI, and samples MISO. It sits between the host-side logic (START/TX_DATA/RX_DATA/DONE) and the SPI pins, and is the master-side counterpart of the flip-flop-based shift datapath.

---
 rtl/spi_master_ctrl_if.sv | 25 ++
 rtl/spi_master_ctrl.sv | 145 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Host and SPI pin bundle for spi_master_ctrl.
// The master modport is the controller view. The slave modport is the surrounding logic's view.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (
    input  start, tx_data, miso,
    output sclk, mosi, cs_n, busy, done, rx_data
  );

  modport slave (
    output start, tx_data, miso,
    input  sclk, mosi, cs_n, busy, done, rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master transaction controller, MSB first, registered pin outputs.
// Each transfer runs through SETUP, DATA_W SCLK pulses, HOLD, and ends with a DONE pulse.
module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                 i_clk,
  input  logic                 i_clr,
  spi_master_ctrl_if.master    bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            r_state,    w_state_nxt;
  logic [CNT_W-1:0]  r_edge_cnt, w_edge_nxt;
  logic [BIT_W-1:0]  r_bit_cnt,  w_bit_nxt;
  logic              r_sclk,     w_sclk_nxt;
  logic              r_mosi,     w_mosi_nxt;
  logic              r_cs_n,     w_cs_n_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_done,     w_done_nxt;
  logic [DATA_W-1:0] r_tx_sr,    w_tx_nxt;
  logic [DATA_W-1:0] r_rx_sr,    w_rx_sr_nxt;
  logic [DATA_W-1:0] r_rx_data,  w_rx_data_nxt;
  logic              w_edge_hit;

  assign w_edge_hit = (r_edge_cnt == EDGE_LAST);

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
    w_state_nxt   = r_state;
    w_edge_nxt    = r_edge_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_sclk_nxt    = r_sclk;
    w_mosi_nxt    = r_mosi;
    w_cs_n_nxt    = r_cs_n;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_tx_nxt      = r_tx_sr;
    w_rx_sr_nxt   = r_rx_sr;
    w_rx_data_nxt = r_rx_data;

    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = SETUP;
          w_tx_nxt    = bus.tx_data;
          w_mosi_nxt  = bus.tx_data[DATA_W-1];
          w_cs_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_edge_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      SETUP: begin
        if (w_edge_hit) begin
          w_edge_nxt  = '0;
          w_sclk_nxt  = 1'b1;
          w_rx_sr_nxt = {r_rx_sr[DATA_W-2:0], bus.miso};
          w_state_nxt = SHIFT;
        end else begin
          w_edge_nxt = r_edge_cnt + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (w_edge_hit) begin
          w_edge_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt  = 1'b1;
            w_rx_sr_nxt = {r_rx_sr[DATA_W-2:0], bus.miso};
          end else begin
            w_sclk_nxt = 1'b0;
            // The last falling edge parks MOSI low and hands over to HOLD.
            if (r_bit_cnt == BIT_LAST) begin
              w_mosi_nxt  = 1'b0;
              w_state_nxt = HOLD;
            end else begin
              w_bit_nxt  = r_bit_cnt + BIT_W'(1);
              w_tx_nxt   = r_tx_sr << 1;
              w_mosi_nxt = r_tx_sr[DATA_W-2];
            end
          end
        end else begin
          w_edge_nxt = r_edge_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (w_edge_hit) begin
          w_edge_nxt    = '0;
          w_cs_n_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_rx_data_nxt = r_rx_sr;
          w_state_nxt   = IDLE;
        end else begin
          w_edge_nxt = r_edge_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: the shift registers are cleared with everything else, so an aborted transfer leaves no residue.
    if (i_clr) begin
      r_state    <= IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
    end else begin
      // NOTE: non-blocking updates let every register see the same pre-edge values.
      r_state    <= w_state_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_tx_sr    <= w_tx_nxt;
      r_rx_sr    <= w_rx_sr_nxt;
      r_rx_data  <= w_rx_data_nxt;
    end
  end

  assign bus.sclk    = r_sclk;
  assign bus.mosi    = r_mosi;
  assign bus.cs_n    = r_cs_n;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: DUT A uses the default divider and DUT B uses CLK_DIV=1.
// Optional loopback ties MOSI to MISO. Outputs are sampled 1 ns after each rising edge.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx = 8'h00;
  logic       miso_drv = 1'b0;
  logic       loop = 1'b0;
  logic       sel = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  spi_master_ctrl_if #(.DATA_W(8)) bus_a ();
  spi_master_ctrl_if #(.DATA_W(8)) bus_b ();

  assign bus_a.start   = start & ~sel;
  assign bus_a.tx_data = tx;
  assign bus_a.miso    = loop ? bus_a.mosi : miso_drv;
  assign bus_b.start   = start & sel;
  assign bus_b.tx_data = tx;
  assign bus_b.miso    = loop ? bus_b.mosi : miso_drv;

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(4)) u_dut_a (.i_clk(clk), .i_clr(clr), .bus(bus_a));
  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(1)) u_dut_b (.i_clk(clk), .i_clr(clr), .bus(bus_b));

  logic       o_sclk, o_mosi, o_cs_n, o_busy, o_done;
  logic [7:0] o_rx;
  assign o_sclk = sel ? bus_b.sclk    : bus_a.sclk;
  assign o_mosi = sel ? bus_b.mosi    : bus_a.mosi;
  assign o_cs_n = sel ? bus_b.cs_n    : bus_a.cs_n;
  assign o_busy = sel ? bus_b.busy    : bus_a.busy;
  assign o_done = sel ? bus_b.done    : bus_a.done;
  assign o_rx   = sel ? bus_b.rx_data : bus_a.rx_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer from acceptance to DONE, with every cycle checked against the mode-0 timing.
  // SCLK rises at n = div*(2k+1) and falls at n = div*(2k+2), so it is high exactly when n/div is odd.
  task automatic xfer(input logic [7:0] tx_val, input int div, input logic [7:0] exp_rx,
                      input logic [7:0] exp_bits, input bit hold, input logic [7:0] tx_late);
    int         last;
    logic       prev_sclk;
    logic [7:0] bits;
    last = div * 17;
    bits = '0;
    start = 1'b1;
    tx = tx_val;
    tick();
    if (!hold) start = 1'b0;
    check("e0_cs_n", o_cs_n, 0);
    check("e0_busy", o_busy, 1);
    check("e0_mosi", o_mosi, tx_val[7]);
    prev_sclk = o_sclk;
    for (int n = 1; n <= last; n++) begin
      tick();
      check("sclk_wave", o_sclk, (n < last) && (((n / div) % 2) == 1));
      check("cs_n_wave", o_cs_n, n == last);
      check("busy_wave", o_busy, n != last);
      check("done_wave", o_done, n == last);
      if (!prev_sclk && o_sclk) bits = {bits[6:0], o_mosi};
      if (n >= div * 16) check("mosi_park", o_mosi, 0);
      prev_sclk = o_sclk;
      if (n == 20) tx = tx_late;
    end
    check("rx_data", o_rx, exp_rx);
    check("mosi_bits", bits, exp_bits);
  endtask

  initial begin
    int  done_seen;
    bit  seen;

    // Reset
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("rst_sclk", o_sclk, 0);
    check("rst_mosi", o_mosi, 0);
    check("rst_cs_n", o_cs_n, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rx",   o_rx,   0);

    // Idle stability, MISO toggling, START low
    for (int n = 0; n < 100; n++) begin
      miso_drv = ~miso_drv;
      tick();
      check("idle_sclk", o_sclk, 0);
      check("idle_cs_n", o_cs_n, 1);
      check("idle_mosi", o_mosi, 0);
      check("idle_done", o_done, 0);
      check("idle_rx",   o_rx,   0);
    end

    // Loopback 0xA5, default divider
    loop = 1'b1;
    xfer(8'hA5, 4, 8'hA5, 8'hA5, 1'b0, 8'hA5);
    tick();
    check("t1_busy_after", o_busy, 0);
    check("t1_rx_held", o_rx, 8'hA5);

    // Bit order 0x3C with MISO held high
    loop = 1'b0;
    miso_drv = 1'b1;
    xfer(8'h3C, 4, 8'hFF, 8'h3C, 1'b0, 8'h3C);

    // Reset mid-transfer at E0+30
    loop = 1'b1;
    start = 1'b1;
    tx = 8'h81;
    tick();
    start = 1'b0;
    for (int n = 1; n < 30; n++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t4_sclk", o_sclk, 0);
    check("t4_cs_n", o_cs_n, 1);
    check("t4_busy", o_busy, 0);
    check("t4_rx",   o_rx,   0);
    check("t4_done", o_done, 0);
    done_seen = 0;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (o_done) done_seen++;
    end
    check("t4_no_done", done_seen, 0);
    xfer(8'h96, 4, 8'h96, 8'h96, 1'b0, 8'h96);

    // Busy rejection: START held, TX_DATA changed to 0x00 at E0+20
    xfer(8'h5A, 4, 8'h5A, 8'h5A, 1'b1, 8'h00);
    tick();
    start = 1'b0;
    check("t3_cs_n_e69", o_cs_n, 0);
    check("t3_busy_e69", o_busy, 1);
    check("t3_mosi_e69", o_mosi, 0);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      if (o_done) seen = 1'b1;
    end
    check("t3_done2_seen", seen, 1);
    check("t3_rx2", o_rx, 8'h00);

    // Minimum divider on DUT B, loopback 0xC3
    sel = 1'b1;
    tick();
    xfer(8'hC3, 1, 8'hC3, 8'hC3, 1'b0, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
